// File: rtl/light_pkg.sv
// Shared definitions for the light mode controller: the per-channel mode
// encoding, its width, and small helpers that give the mode sequence and
// the light level each mode produces.
package light_pkg;

    // Width of one channel's mode field in the packed mode output.
    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF  = 2'b00,
        MODE_ON   = 2'b01,
        MODE_FAST = 2'b10,
        MODE_SLOW = 2'b11
    } mode_e;

    // Mode sequence on each button press: OFF -> ON -> FAST -> SLOW -> OFF.
    function automatic mode_e mode_advance(input mode_e cur);
        mode_e nxt;
        case (cur)
            MODE_OFF:  nxt = MODE_ON;
            MODE_ON:   nxt = MODE_FAST;
            MODE_FAST: nxt = MODE_SLOW;
            MODE_SLOW: nxt = MODE_OFF;
            default:   nxt = MODE_OFF;
        endcase
        return nxt;
    endfunction

    // Light level for one channel given its mode and the shared blink levels.
    function automatic logic mode_light(input mode_e cur,
                                        input logic  fast_lvl,
                                        input logic  slow_lvl);
        logic lvl;
        case (cur)
            MODE_OFF:  lvl = 1'b0;
            MODE_ON:   lvl = 1'b1;
            MODE_FAST: lvl = fast_lvl;
            MODE_SLOW: lvl = slow_lvl;
            default:   lvl = 1'b0;
        endcase
        return lvl;
    endfunction

endpackage : light_pkg

// File: rtl/blink_gen.sv
// Free-running 50% square-wave generator. A counter runs over 0..HALF-1 and
// the output level toggles each time it wraps, so the level is high for HALF
// clocks and low for HALF clocks. Both counter and level clear on reset, so
// the first rising toggle lands HALF clocks after reset release.
module blink_gen #(
    parameter int HALF = 4
) (
    input  logic clk,
    input  logic reset,
    output logic level
);

    // HALF == 1 still needs a one-bit counter; it simply never leaves 0.
    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_q;
    logic          level_d;
    logic          wrap;

    // Next counter value and level: wrap to 0 and toggle at the end of a half-period.
    always_comb begin
        wrap    = (cnt_q == LAST);
        cnt_d   = wrap ? '0 : cnt_q + CW'(1);
        level_d = wrap ? ~level_q : level_q;
    end

    // Counter and level registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule : blink_gen

// File: rtl/light_mode_ctrl.sv
// Multi-channel light mode controller. Each channel holds a 2-bit mode that
// advances OFF -> ON -> FAST -> SLOW -> OFF on every rising edge of its
// next_mode input. Two shared free-running blink generators supply the fast
// and slow blink levels, so channels in the same blink mode stay in phase.
// The light outputs are registered (one clock of latency); mode is driven
// straight from the mode registers.
//
// Optional feature, enabled by defining LIGHT_MODE_CTRL_BRAKE_OVERRIDE_EN:
// while brake is sampled high every light is forced on (one clock later),
// without disturbing the mode registers or blink generators. In the default
// build brake is ignored and no brake logic exists.
//
// Legal configuration: NUM_CH in 1..16, FAST_HALF >= 1, SLOW_HALF > FAST_HALF.
module light_mode_ctrl
    import light_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int FAST_HALF = 4,
    parameter int SLOW_HALF = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        next_mode,
    input  logic                     brake,
    output logic [NUM_CH-1:0]        lights,
    output logic [MODE_W*NUM_CH-1:0] mode
);

    logic [NUM_CH-1:0] next_mode_q;
    logic              armed_q;
    logic [NUM_CH-1:0] rise;
    mode_e             mode_q [NUM_CH];
    mode_e             mode_d [NUM_CH];
    logic [NUM_CH-1:0] lights_q;
    logic [NUM_CH-1:0] lights_d;
    logic              fast_lvl;
    logic              slow_lvl;

    blink_gen #(
        .HALF (FAST_HALF)
    ) u_fast_blink (
        .clk   (clk),
        .reset (reset),
        .level (fast_lvl)
    );

    blink_gen #(
        .HALF (SLOW_HALF)
    ) u_slow_blink (
        .clk   (clk),
        .reset (reset),
        .level (slow_lvl)
    );

    // Edge detector history. armed_q stays low for the first clock after
    // reset release so that a button already held at release is only
    // sampled into the history, never reported as a fresh press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            next_mode_q <= '0;
            armed_q     <= 1'b0;
        end else begin
            next_mode_q <= next_mode;
            armed_q     <= 1'b1;
        end
    end

    // Per-channel press detection and next mode; channels are independent.
    always_comb begin
        rise = next_mode & ~next_mode_q & {NUM_CH{armed_q}};
        for (int i = 0; i < NUM_CH; i++) begin
            mode_d[i] = rise[i] ? mode_advance(mode_q[i]) : mode_q[i];
        end
    end

    // Mode registers, one per channel, cleared to OFF by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i] <= MODE_OFF;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i] <= mode_d[i];
            end
        end
    end

    // Light value for the next clock from the current mode and blink levels.
`ifdef LIGHT_MODE_CTRL_BRAKE_OVERRIDE_EN
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            lights_d[i] = mode_light(mode_q[i], fast_lvl, slow_lvl);
        end
        if (brake) begin
            lights_d = '1;
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            lights_d[i] = mode_light(mode_q[i], fast_lvl, slow_lvl);
        end
    end

    // brake has no function in this build.
    logic unused_brake;
    assign unused_brake = brake;
`endif

    // Registered light drive, cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lights_q <= '0;
        end else begin
            lights_q <= lights_d;
        end
    end

    assign lights = lights_q;

    // Pack each channel's mode into its 2-bit slot of the mode output.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_mode_out
        assign mode[MODE_W*g +: MODE_W] = mode_q[g];
    end

endmodule : light_mode_ctrl

// File: tb/tb_light_mode_ctrl.sv
// Testbench for light_mode_ctrl. A reference model tracks each channel's mode
// as a press count modulo 4 and derives the blink levels arithmetically from
// the number of clocks since reset release. Directed phases cover reset,
// free-running blink, mode cycling, a held button, phase alignment,
// mid-operation reset and brake; a randomized phase follows.
module tb_light_mode_ctrl;

    localparam int NUM_CH = 2;
    localparam int FH     = 4;
    localparam int SH     = 8;

    logic                  clk;
    logic                  reset;
    logic [NUM_CH-1:0]     next_mode;
    logic                  brake;
    logic [NUM_CH-1:0]     lights;
    logic [2*NUM_CH-1:0]   mode;

    int pass_cnt;
    int fail_cnt;
    int total_cnt;

    // Reference model state.
    logic [1:0]        mode_m [NUM_CH];
    logic [NUM_CH-1:0] prev_m;
    bit                armed_m;
    int                t_m;

    light_mode_ctrl #(
        .NUM_CH    (NUM_CH),
        .FAST_HALF (FH),
        .SLOW_HALF (SH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .next_mode (next_mode),
        .brake     (brake),
        .lights    (lights),
        .mode      (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) mode_m[i] = 2'd0;
        prev_m  = '0;
        armed_m = 1'b0;
        t_m     = 0;
    endtask

    // Advance one clock, update the model from the inputs present at the
    // edge, then compare both outputs.
    task automatic step(input string tag);
        logic [NUM_CH-1:0]   exp_l;
        logic [2*NUM_CH-1:0] exp_m;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            case (mode_m[i])
                2'd0:    exp_l[i] = 1'b0;
                2'd1:    exp_l[i] = 1'b1;
                2'd2:    exp_l[i] = ((t_m / FH) % 2) == 1;
                default: exp_l[i] = ((t_m / SH) % 2) == 1;
            endcase
        end
`ifdef LIGHT_MODE_CTRL_BRAKE_OVERRIDE_EN
        if (brake) exp_l = '1;
`endif
        t_m++;
        for (int i = 0; i < NUM_CH; i++) begin
            if (armed_m && next_mode[i] && !prev_m[i]) mode_m[i] = mode_m[i] + 2'd1;
        end
        prev_m  = next_mode;
        armed_m = 1'b1;
        for (int i = 0; i < NUM_CH; i++) exp_m[2*i +: 2] = mode_m[i];
        chk({tag, "_mode"}, 32'(mode), 32'(exp_m));
        chk({tag, "_lights"}, 32'(lights), 32'(exp_l));
    endtask

    task automatic press(input int ch);
        next_mode[ch] = 1'b1;
        step("press_hi");
        next_mode[ch] = 1'b0;
        step("press_lo");
    endtask

    // Asynchronous reset pulse mid-cycle; outputs must clear without a clock.
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_async_mode", 32'(mode), 32'd0);
        chk("rst_async_lights", 32'(lights), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_mode", 32'(mode), 32'd0);
        chk("rst_hold_lights", 32'(lights), 32'd0);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [1:0] cyc_exp [4];
        pass_cnt  = 0;
        fail_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b1;
        next_mode = '0;
        brake     = 1'b0;
        cyc_exp   = '{2'b01, 2'b10, 2'b11, 2'b00};
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("reset_mode", 32'(mode), 32'd0);
        chk("reset_lights", 32'(lights), 32'd0);
        reset = 1'b0;
        model_reset();

        // Free-running blink with every channel OFF: lights stay dark.
        repeat (16) step("idle");

        // Mode cycling on channel 0; channel 1 untouched.
        for (int k = 0; k < 4; k++) begin
            press(0);
            chk("cycle_ch0", 32'(mode[1:0]), 32'(cyc_exp[k]));
            chk("cycle_ch1", 32'(mode[3:2]), 32'd0);
        end

        // Held button on channel 1 advances exactly once.
        next_mode[1] = 1'b1;
        repeat (20) step("held");
        next_mode[1] = 1'b0;
        step("held_rel");
        chk("held_once", 32'(mode[3:2]), 32'd1);
        chk("held_light", 32'(lights[1]), 32'd1);

        // Bring both channels to SLOW, then reset mid-operation.
        repeat (3) press(0);
        repeat (2) press(1);
        chk("both_slow", 32'(mode), 32'hF);
        repeat (5) step("slow_run");
        do_reset();
        repeat (6) step("post_rst");

        // Phase alignment: channel 0 FAST, channel 1 FAST three clocks later.
        repeat (2) press(0);
        repeat (3) step("gap");
        repeat (2) press(1);
        repeat (24) step("aligned");

        // Brake: channel 0 OFF, channel 1 FAST.
        repeat (2) press(0);
        chk("brake_setup", 32'(mode), 32'h8);
        brake = 1'b1;
        repeat (5) step("brake_on");
        brake = 1'b0;
        repeat (6) step("brake_off");

        // Button already high when reset releases must not count as a press.
        next_mode = '1;
        do_reset();
        repeat (3) step("rel_high");
        chk("rel_high_mode", 32'(mode), 32'd0);
        next_mode = '0;
        step("rel_low");

        // Randomized presses and brake against the model.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(0, 3) == 0) next_mode[i] = ~next_mode[i];
            end
            brake = ($urandom_range(0, 7) == 0);
            step("rand");
        end
        brake     = 1'b0;
        next_mode = '0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_light_mode_ctrl

// File: doc/light_mode_ctrl.md
LIGHT_MODE_CTRL -- requirements
Module: light_mode_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent light channels, legal range 1..16.
REQ-002 SHALL have parameter FAST_HALF, default 4: fast-blink half-period in clocks, minimum 1.
REQ-003 SHALL have parameter SLOW_HALF, default 8: slow-blink half-period in clocks; must be greater than FAST_HALF.
REQ-004 SHALL have port clk, input, width 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, width 1: asynchronous, active-high reset.
REQ-006 SHALL have port next_mode, input, width NUM_CH: per-channel mode-advance request (level input, e.g. debounced button).
REQ-007 SHALL have port brake, input, width 1: brake override request; used only when BRAKE_OVERRIDE_EN is defined.
REQ-008 SHALL have port lights, output, width NUM_CH: registered light drive, one bit per channel.
REQ-009 SHALL have port mode, output, width 2*NUM_CH: current 2-bit mode of each channel; channel i occupies bits [2i+1:2i].

Function
REQ-010 SHALL use these mode encodings: OFF=00, ON=01, FAST=10, SLOW=11.
REQ-011 SHALL keep one mode register per channel and advance it on each rising edge of next_mode[i]: OFF->ON->FAST->SLOW->OFF, wrapping from SLOW to OFF.
REQ-012 SHALL detect rising edges with a registered copy of next_mode: a level held high for N cycles advances the mode exactly once; the mode register changes on the clock edge after the sampled 0->1 transition.
REQ-013 SHALL run one shared fast-blink generator: a counter over 0..FAST_HALF-1; the fast level toggles on each wrap, giving a 50% square wave with period 2*FAST_HALF clocks.
REQ-014 SHALL run one shared slow-blink generator with the same rules using SLOW_HALF.
REQ-015 SHALL run the blink generators freely; they SHALL NOT restart on mode changes, so all channels in the same blink mode are phase-aligned.
REQ-016 SHALL register lights[i] as f(mode_i, fast, slow), giving 1-cycle latency: OFF->0, ON->1, FAST->fast level, SLOW->slow level.
REQ-017 SHALL drive the mode output directly from the mode registers, with no added latency.
REQ-018 SHALL treat a mode advance and a blink toggle in the same cycle as independent; on the following cycle lights reflects the new mode with the new blink level.
REQ-019 SHALL advance every channel that sees a rising edge in the same cycle; channels do not interact.

Reset
REQ-020 SHALL, while reset is asserted, force all of the following to 0 asynchronously: mode registers (OFF), edge-detect registers, both blink counters, both blink levels, and lights.
REQ-021 SHALL abandon any in-progress mode advance or blink phase when reset is asserted mid-operation; nothing is retained.
REQ-022 SHALL treat a next_mode level that is already high at reset release as no edge, because the edge-detect register samples it first.
REQ-023 SHALL start both blink levels at 0 after reset release; the first fast toggle to 1 occurs FAST_HALF clocks after release.

Configuration
REQ-024 SHALL, with LIGHT_MODE_CTRL_BRAKE_OVERRIDE_EN defined, drive every lights bit to 1 on the cycle after brake is sampled high, regardless of mode; mode registers and blink generators continue unaffected, and normal output resumes 1 cycle after brake falls.
REQ-025 SHALL, without LIGHT_MODE_CTRL_BRAKE_OVERRIDE_EN, ignore brake and compile no brake logic.

Structure
REQ-026 SHALL place the mode encodings (OFF/ON/FAST/SLOW) and the mode width constant (2) in shared package light_pkg.
REQ-027 SHALL implement each blink generator as an instance of sub-module blink_gen (parameter HALF; ports clk, reset, level), instantiated twice.

Verification
REQ-028 SHALL check free-running blink (NUM_CH=2, FAST_HALF=4, SLOW_HALF=8): release reset, all modes OFF -> lights=00 throughout; fast level high on cycles 4-7 and 12-15 after release; slow level high on cycles 8-15.
REQ-029 SHALL check mode cycling: pulse next_mode[0] four times -> mode[1:0] goes 01, 10, 11, 00; mode[3:2] stays 00.
REQ-030 SHALL check a held button: hold next_mode[1] high for 20 cycles -> mode[3:2] advances exactly once, to 01, and lights[1]=1 two cycles after the edge.
REQ-031 SHALL check phase alignment: channel 0 in FAST, channel 1 set to FAST 3 cycles later -> lights[0]==lights[1] on every cycle after channel 1's output latency.
REQ-032 SHALL check mid-operation reset: both channels in SLOW, assert reset for 1 cycle -> mode=0000 and lights=00 immediately, with counters restarting from 0.
REQ-033 SHALL check brake override (macro defined): channel 0 OFF, channel 1 FAST, brake high for 5 cycles -> lights=11 for those cycles (1-cycle lag), mode unchanged; with the macro undefined, lights are unaffected by brake.
